// File: rtl/instr_fetch_mem.sv
// instr_fetch_mem: byte-addressed, big-endian instruction memory with a
// fetch request/response pipeline of LATENCY stages, fault reporting for
// misaligned / out-of-range fetches and flush of in-flight fetches.
// Optional feature macro: IMEM_LOAD_EN adds a byte-wide load (write) port
// that takes priority over fetches.
module instr_fetch_mem #(
    parameter int    DEPTH_BYTES = 256,
    parameter int    INSTR_W     = 32,
    parameter int    LATENCY     = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_req,
    input  logic [31:0]        fetch_addr,
    output logic               fetch_ready,
    input  logic               flush,
    output logic               resp_valid,
    output logic [INSTR_W-1:0] resp_instr,
    output logic               resp_fault
`ifdef IMEM_LOAD_EN
    ,
    input  logic               load_we,
    input  logic [31:0]        load_addr,
    input  logic [7:0]         load_data
`endif
);

    localparam int NB = INSTR_W / 8;
    localparam int AW = $clog2(DEPTH_BYTES);

    // Byte storage; never reset.
    logic [7:0] mem_q [DEPTH_BYTES];

    // Power-up image: all bytes zero.
    initial begin
        for (int i = 0; i < DEPTH_BYTES; i++) mem_q[i] = 8'h00;
    end

    // Pipeline stages 1..LATENCY; stage LATENCY drives the outputs directly.
    logic [LATENCY:1]   vld_q, vld_d;
    logic [INSTR_W-1:0] ins_q [1:LATENCY];
    logic [INSTR_W-1:0] ins_d [1:LATENCY];
    logic               flt_q [1:LATENCY];
    logic               flt_d [1:LATENCY];

    logic               accept;
    logic               fault;
    logic [AW-1:0]      base_idx;
    logic [INSTR_W-1:0] rd_word;

`ifdef IMEM_LOAD_EN
    assign fetch_ready = !reset && !load_we;
`else
    assign fetch_ready = !reset;
`endif

    assign accept   = fetch_req && fetch_ready;
    assign base_idx = fetch_addr[AW-1:0];

    // Fault decode and big-endian word assembly; storage is only indexed when in range.
    always_comb begin
        fault   = ((fetch_addr % 32'(NB)) != 32'd0) ||
                  (fetch_addr > 32'(DEPTH_BYTES - NB));
        rd_word = '0;
        if (!fault) begin
            for (int k = 0; k < NB; k++)
                rd_word[INSTR_W-1-8*k -: 8] = mem_q[base_idx + AW'(k)];
        end
    end

    // Next-state of the pipeline: shift, flush masking, and output hold.
    always_comb begin
        vld_d = vld_q;
        ins_d = ins_q;
        flt_d = flt_q;
        // Stage 1 takes the newly accepted fetch; a same-cycle flush keeps it.
        vld_d[1] = accept;
        if (LATENCY > 1 || accept) begin
            ins_d[1] = rd_word;
            flt_d[1] = fault;
        end
        // Later stages: flush kills fetches accepted before this cycle.
        // The output stage only loads payload when a valid fetch arrives,
        // so resp_instr/resp_fault hold between responses.
        for (int s = 2; s <= LATENCY; s++) begin
            vld_d[s] = vld_q[s-1] && !flush;
            if (s < LATENCY || vld_d[s]) begin
                ins_d[s] = ins_q[s-1];
                flt_d[s] = flt_q[s-1];
            end
        end
    end

    // Pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            for (int s = 1; s <= LATENCY; s++) begin
                ins_q[s] <= '0;
                flt_q[s] <= 1'b0;
            end
        end else begin
            vld_q <= vld_d;
            ins_q <= ins_d;
            flt_q <= flt_d;
        end
    end

`ifdef IMEM_LOAD_EN
    // Byte load port; out-of-range writes are dropped, reset blocks writes.
    always_ff @(posedge clk) begin
        if (!reset && load_we && (load_addr < 32'(DEPTH_BYTES)))
            mem_q[load_addr[AW-1:0]] <= load_data;
    end
`endif

    assign resp_valid = vld_q[LATENCY];
    assign resp_instr = ins_q[LATENCY];
    assign resp_fault = flt_q[LATENCY];

endmodule
